// File: rtl/ysyx_24090012_lsu.sv
// ysyx_24090012_lsu -- load/store unit between the EXU and a simple
// valid/ready memory bus, delivering results to the WBU.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   exu_*             : instruction offer from EXU (valid/ready), address,
//                       store data, instruction word, ALU result
//   bus_req_*         : memory request (valid/ready), word address, write
//                       enable, lane-replicated data, byte strobes
//   bus_rsp_*         : one-cycle response pulse with read data and error
//   wb_*              : result offer to WBU (valid/ready), instruction,
//                       rd data, access-fault flag
//   state_out         : FSM state (IDLE=00, REQ=01, WAIT=10, WB=11)
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both 1. A valid source holds its payload stable until that edge; ready
// may change freely.
module ysyx_24090012_lsu #(
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic [31:0] exu_addr,
  input  logic [31:0] exu_wdata,
  input  logic [31:0] exu_inst,
  input  logic [31:0] exu_rd_data,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_req_addr,
  output logic        bus_req_wen,
  output logic [31:0] bus_req_wdata,
  output logic [3:0]  bus_req_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  input  logic        bus_rsp_err,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_inst,
  output logic [31:0] wb_data,
  output logic        wb_err,
  output logic [1:0]  state_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    WB   = 2'b11
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2:0]     funct3_q;
  logic [1:0]     off_q;
  logic           is_load_q;

  // Decode of the instruction currently offered by the EXU.
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        is_load;
  logic        is_store;
  logic        access_ok;
  logic [3:0]  st_strb;
  logic [31:0] st_data;

  always_comb begin
    f3        = exu_inst[14:12];
    off       = exu_addr[1:0];
    is_load   = (exu_inst[6:0] == 7'b0000011);
    is_store  = (exu_inst[6:0] == 7'b0100011);
    access_ok = 1'b0;
    st_strb   = 4'b0000;
    st_data   = exu_wdata;
    if (is_load) begin
      case (f3)
        3'b000, 3'b100: access_ok = 1'b1;
        3'b001, 3'b101: access_ok = ~off[0];
        3'b010:         access_ok = (off == 2'b00);
        default:        access_ok = 1'b0;  // unknown width: fault
      endcase
    end else if (is_store) begin
      case (f3)
        3'b000: begin
          access_ok = 1'b1;
          st_strb   = 4'b0001 << off;
          st_data   = {4{exu_wdata[7:0]}};
        end
        3'b001: begin
          access_ok = ~off[0];
          st_strb   = off[1] ? 4'b1100 : 4'b0011;
          st_data   = {2{exu_wdata[15:0]}};
        end
        3'b010: begin
          access_ok = (off == 2'b00);
          st_strb   = 4'b1111;
        end
        default: access_ok = 1'b0;
      endcase
    end
  end

  // Load result: shift the addressed lane down, then extend by width.
  logic [31:0] lane;
  logic [31:0] ld_data;

  always_comb begin
    lane = bus_rsp_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'd0, lane[7:0]};
      3'b101:  ld_data = {16'd0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      is_load_q     <= 1'b0;
      bus_req_addr  <= 32'd0;
      bus_req_wen   <= 1'b0;
      bus_req_wdata <= 32'd0;
      bus_req_wstrb <= 4'b0000;
      wb_inst       <= 32'd0;
      wb_data       <= 32'd0;
      wb_err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (exu_valid) begin
            wb_inst   <= exu_inst;
            funct3_q  <= f3;
            off_q     <= off;
            is_load_q <= is_load;
            if (!is_load && !is_store) begin
              wb_data <= exu_rd_data;
              wb_err  <= 1'b0;
              state   <= WB;
            end else if (!access_ok) begin
              wb_data <= 32'd0;
              wb_err  <= 1'b1;
              state   <= WB;
            end else begin
              bus_req_addr  <= {exu_addr[31:2], 2'b00};
              bus_req_wen   <= is_store;
              bus_req_wdata <= is_store ? st_data : 32'd0;
              bus_req_wstrb <= st_strb;
              cnt           <= '0;
              state         <= REQ;
            end
          end
        end
        REQ: begin
          // A request accepted on the final budget cycle still gets WAIT;
          // the counter then sits at/after the limit and WAIT aborts next.
          if (bus_req_ready) begin
            cnt   <= cnt + 1'b1;
            state <= WAIT;
          end else if (cnt >= CNT_LAST) begin
            wb_data <= 32'd0;
            wb_err  <= 1'b1;
            state   <= WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT: begin
          if (bus_rsp_valid) begin
            wb_err  <= bus_rsp_err;
            wb_data <= (bus_rsp_err || !is_load_q) ? 32'd0 : ld_data;
            state   <= WB;
          end else if (cnt >= CNT_LAST) begin
            wb_data <= 32'd0;
            wb_err  <= 1'b1;
            state   <= WB;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: begin
          if (wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign exu_ready     = (state == IDLE);
  assign bus_req_valid = (state == REQ);
  assign wb_valid      = (state == WB);
  assign state_out     = state;

endmodule

// File: tb/tb_ysyx_24090012_lsu.sv
// Directed testbench for ysyx_24090012_lsu (instantiated with TIMEOUT=8).
module tb_ysyx_24090012_lsu;

  logic        clk;
  logic        rst;
  logic        exu_valid;
  logic        exu_ready;
  logic [31:0] exu_addr;
  logic [31:0] exu_wdata;
  logic [31:0] exu_inst;
  logic [31:0] exu_rd_data;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_req_addr;
  logic        bus_req_wen;
  logic [31:0] bus_req_wdata;
  logic [3:0]  bus_req_wstrb;
  logic        bus_rsp_valid;
  logic [31:0] bus_rsp_rdata;
  logic        bus_rsp_err;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_inst;
  logic [31:0] wb_data;
  logic        wb_err;
  logic [1:0]  state_out;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  ysyx_24090012_lsu #(.TIMEOUT(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .exu_valid     (exu_valid),
    .exu_ready     (exu_ready),
    .exu_addr      (exu_addr),
    .exu_wdata     (exu_wdata),
    .exu_inst      (exu_inst),
    .exu_rd_data   (exu_rd_data),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_req_addr  (bus_req_addr),
    .bus_req_wen   (bus_req_wen),
    .bus_req_wdata (bus_req_wdata),
    .bus_req_wstrb (bus_req_wstrb),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_rdata (bus_rsp_rdata),
    .bus_rsp_err   (bus_rsp_err),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_inst       (wb_inst),
    .wb_data       (wb_data),
    .wb_err        (wb_err),
    .state_out     (state_out)
  );

  // Driver tasks: inputs change and outputs are sampled 1ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rd);
    exu_valid   = 1'b1;
    exu_inst    = inst;
    exu_addr    = addr;
    exu_wdata   = wdata;
    exu_rd_data = rd;
    step();
    exu_valid   = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rdata, input logic err);
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = rdata;
    bus_rsp_err   = err;
    step();
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; exu_valid = 1'b0; exu_addr = '0; exu_wdata = '0; exu_inst = '0;
    exu_rd_data = '0; bus_req_ready = 1'b1; bus_rsp_valid = 1'b0;
    bus_rsp_rdata = '0; bus_rsp_err = 1'b0; wb_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_state", 32'(state_out), 32'h0);
    check("rst_exu_ready", 32'(exu_ready), 32'h1);
    check("rst_req_valid", 32'(bus_req_valid), 32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_wb_err", 32'(wb_err), 32'h0);
    check("rst_req_addr", bus_req_addr, 32'h0);

    // ADDI pass-through
    offer(32'h12300093, 32'h0, 32'h0, 32'h00001234);
    check("addi_state", 32'(state_out), 32'h3);
    check("addi_wb_valid", 32'(wb_valid), 32'h1);
    check("addi_wb_data", wb_data, 32'h00001234);
    check("addi_wb_err", 32'(wb_err), 32'h0);
    check("addi_wb_inst", wb_inst, 32'h12300093);
    check("addi_no_bus", 32'(bus_req_valid), 32'h0);
    check("addi_exu_ready", 32'(exu_ready), 32'h0);
    step();
    check("addi_idle", 32'(state_out), 32'h0);

    // LB, zero-wait: accept N, req N+1, rsp N+2, wb N+3
    offer(32'h00050083, 32'h80000003, 32'h0, 32'h0);
    check("lb_req_valid", 32'(bus_req_valid), 32'h1);
    check("lb_req_addr", bus_req_addr, 32'h80000000);
    check("lb_req_wen", 32'(bus_req_wen), 32'h0);
    check("lb_req_wstrb", 32'(bus_req_wstrb), 32'h0);
    step();
    check("lb_wait_state", 32'(state_out), 32'h2);
    check("lb_wait_req_valid", 32'(bus_req_valid), 32'h0);
    respond(32'h80FF0000, 1'b0);
    check("lb_wb_valid", 32'(wb_valid), 32'h1);
    check("lb_wb_data", wb_data, 32'hFFFFFF80);
    check("lb_wb_err", 32'(wb_err), 32'h0);
    step();

    // SH to upper half
    offer(32'h00A51123, 32'h80000002, 32'hAAAA5678, 32'h0);
    check("sh_req_wen", 32'(bus_req_wen), 32'h1);
    check("sh_req_wstrb", 32'(bus_req_wstrb), 32'hC);
    check("sh_req_wdata", bus_req_wdata, 32'h56785678);
    check("sh_req_addr", bus_req_addr, 32'h80000000);
    step();
    respond(32'h12345678, 1'b0);
    check("sh_wb_data", wb_data, 32'h0);
    check("sh_wb_err", 32'(wb_err), 32'h0);
    step();

    // SB at byte 1
    offer(32'h00A500A3, 32'h80000001, 32'h000000AB, 32'h0);
    check("sb_req_wstrb", 32'(bus_req_wstrb), 32'h2);
    check("sb_req_wdata", bus_req_wdata, 32'hABABABAB);
    step();
    respond(32'h0, 1'b1);
    check("sb_buserr_err", 32'(wb_err), 32'h1);
    check("sb_buserr_data", wb_data, 32'h0);
    step();

    // LHU at upper half
    offer(32'h00055083, 32'h80000002, 32'h0, 32'h0);
    step();
    respond(32'h8001BEEF, 1'b0);
    check("lhu_wb_data", wb_data, 32'h00008001);
    step();

    // LW misaligned: fault, no bus access
    offer(32'h00052083, 32'h80000001, 32'h0, 32'h0);
    check("lw_mis_state", 32'(state_out), 32'h3);
    check("lw_mis_no_bus", 32'(bus_req_valid), 32'h0);
    check("lw_mis_err", 32'(wb_err), 32'h1);
    check("lw_mis_data", wb_data, 32'h0);
    step();

    // Unknown load funct3 (011): fault
    offer(32'h00053083, 32'h80000000, 32'h0, 32'h0);
    check("f3_bad_no_bus", 32'(bus_req_valid), 32'h0);
    check("f3_bad_err", 32'(wb_err), 32'h1);
    step();

    // Back-pressure on request and writeback
    bus_req_ready = 1'b0;
    offer(32'h00052083, 32'h80000004, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_valid", 32'(bus_req_valid), 32'h1);
      check("bp_req_addr", bus_req_addr, 32'h80000004);
      check("bp_req_wstrb", 32'(bus_req_wstrb), 32'h0);
      step();
    end
    bus_req_ready = 1'b1;
    check("bp_req_still_valid", 32'(bus_req_valid), 32'h1);
    step();
    bus_req_ready = 1'b0;
    wb_ready = 1'b0;
    respond(32'hDEADBEEF, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("bp_wb_valid", 32'(wb_valid), 32'h1);
      check("bp_wb_data", wb_data, 32'hDEADBEEF);
      check("bp_wb_inst", wb_inst, 32'h00052083);
      step();
    end
    // Release WB while EXU already offers: must not be accepted this edge.
    wb_ready = 1'b1;
    exu_valid = 1'b1; exu_inst = 32'h00100093; exu_rd_data = 32'h55;
    step();
    exu_valid = 1'b0;
    check("bp_back_idle", 32'(state_out), 32'h0);
    check("bp_idle_wb_valid", 32'(wb_valid), 32'h0);

    // Timeout: no response, 8 REQ/WAIT cycles then fault
    bus_req_ready = 1'b1;
    offer(32'h00052083, 32'h80000008, 32'h0, 32'h0);
    for (int i = 0; i < 7; i++) step();
    check("to_still_wait", 32'(state_out), 32'h2);
    step();
    check("to_state_wb", 32'(state_out), 32'h3);
    check("to_err", 32'(wb_err), 32'h1);
    check("to_data", wb_data, 32'h0);
    check("to_req_valid", 32'(bus_req_valid), 32'h0);
    step();
    respond(32'h11111111, 1'b1);
    check("stray_rsp_state", 32'(state_out), 32'h0);
    check("stray_rsp_wb_valid", 32'(wb_valid), 32'h0);

    // Reset in the middle of a request
    bus_req_ready = 1'b0;
    offer(32'h00052083, 32'h80000010, 32'h0, 32'h0);
    check("mid_rst_in_req", 32'(bus_req_valid), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_req_valid", 32'(bus_req_valid), 32'h0);
    check("mid_rst_state", 32'(state_out), 32'h0);
    check("mid_rst_exu_ready", 32'(exu_ready), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
